// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider.
// It produces one quotient bit per clock and supports signed or unsigned
// operation per transfer. Operands and results use valid/ready handshakes.
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int SIGNED_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DIVIDEND_W-1:0] i_up,
  input  logic [DIVISOR_W-1:0]  i_bo,
  input  logic                  i_signed,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DIVIDEND_W-1:0] o_quot,
  output logic [DIVISOR_W-1:0]  o_rem,
  output logic                  o_div0,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Dividend magnitude shifts out at the top while quotient bits enter at the bottom.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  part_q, part_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  div0_q, div0_d;
  logic                  valid_q, valid_d;

  logic                  sgn_op, up_neg, bo_neg;
  logic [DIVIDEND_W-1:0] up_abs;
  logic [DIVISOR_W-1:0]  bo_abs;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  diff;
  logic [DIVISOR_W-1:0]  part_nxt;
  logic [DIVIDEND_W-1:0] dvd_nxt;
  logic [DIVIDEND_W-1:0] quot_fix;
  logic [DIVISOR_W-1:0]  rem_fix;

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_valid = valid_q;
  assign o_quot  = quot_q;
  assign o_rem   = rem_q;
  assign o_div0  = div0_q;

  // Operand magnitudes and signs for the pair being offered on the input port.
  always_comb begin
    sgn_op = (SIGNED_EN != 0) && i_signed;
    up_neg = sgn_op && i_up[DIVIDEND_W-1];
    bo_neg = sgn_op && i_bo[DIVISOR_W-1];
    up_abs = up_neg ? -i_up : i_up;
    bo_abs = bo_neg ? -i_bo : i_bo;
  end

  // One restoring-division step plus sign correction of the would-be final result.
  // The partial remainder stays below the divisor magnitude, so once shifted it
  // fits in DIVISOR_W+1 bits. The difference fits in DIVISOR_W bits.
  always_comb begin
    shifted  = {part_q, dvd_q[DIVIDEND_W-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    diff     = shifted[DIVISOR_W-1:0] - dvs_q;
    part_nxt = ge ? diff : shifted[DIVISOR_W-1:0];
    dvd_nxt  = {dvd_q[DIVIDEND_W-2:0], ge};
    quot_fix = neg_quot_q ? -dvd_nxt : dvd_nxt;
    rem_fix  = neg_rem_q ? -part_nxt : part_nxt;
  end

  // FSM next state, datapath updates and result registration.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    part_d     = part_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div0_d     = div0_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          neg_quot_d = up_neg ^ bo_neg;
          neg_rem_d  = up_neg;
          dvd_d      = up_abs;
          dvs_d      = bo_abs;
          part_d     = '0;
          if (i_bo == '0) begin
            // Zero divisor: the result is ready at once and the raw dividend bits are returned.
            quot_d  = '1;
            rem_d   = i_up[DIVISOR_W-1:0];
            div0_d  = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d  = dvd_nxt;
        part_d = part_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quot_d  = quot_fix;
          rem_d   = rem_fix;
          div0_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register. An asynchronous reset aborts any division in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      part_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div0_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      part_q     <= part_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div0_q     <= div0_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider, with a short randomized run against a
// behavioural division model. It includes a second instance built with
// SIGNED_EN=0 that shares the stimulus.
module tb_seq_divider;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_up;
  logic [7:0]  i_bo;
  logic        i_signed;

  logic        o_ready, o_valid, o_div0, o_busy;
  logic [15:0] o_quot;
  logic [7:0]  o_rem;

  logic        u_ready, u_valid, u_div0, u_busy;
  logic [15:0] u_quot;
  logic [7:0]  u_rem;

  int total = 0;
  int bad   = 0;

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8), .SIGNED_EN(1)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_up(i_up), .i_bo(i_bo), .i_signed(i_signed), .o_valid(o_valid),
    .i_ready(i_ready), .o_quot(o_quot), .o_rem(o_rem), .o_div0(o_div0),
    .o_busy(o_busy)
  );

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8), .SIGNED_EN(0)) dut_u (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(u_ready),
    .i_up(i_up), .i_bo(i_bo), .i_signed(i_signed), .o_valid(u_valid),
    .i_ready(i_ready), .o_quot(u_quot), .o_rem(u_rem), .o_div0(u_div0),
    .o_busy(u_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one pair while o_ready is high, then wait (bounded) for o_valid.
  // lat counts the rising edges from the accept edge to the first edge that sees o_valid high.
  task automatic run_op(input logic [15:0] up, input logic [7:0] bo, input logic sg,
                        output int lat);
    i_up = up; i_bo = bo; i_signed = sg; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_up = 16'($urandom); i_bo = 8'($urandom); i_signed = 1'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Complete the result handshake (i_ready must be 1) and confirm the divider is free again.
  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    chk({tag, "_hs_valid"}, o_valid, 0);
    chk({tag, "_ready_back"}, o_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [15:0] up, input logic [7:0] bo,
                          input logic sg, input logic [15:0] eq, input logic [7:0] er,
                          input logic ed, input int elat);
    int lat;
    run_op(up, bo, sg, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_quot"}, o_quot, eq);
    chk({tag, "_rem"}, o_rem, er);
    chk({tag, "_div0"}, o_div0, ed);
    finish_op(tag);
  endtask

  function automatic void model(input logic [15:0] up, input logic [7:0] bo, input logic sg,
                                output logic [15:0] q, output logic [7:0] r);
    int a, b;
    if (bo == 8'd0) begin
      q = 16'hFFFF;
      r = up[7:0];
    end else if (sg) begin
      a = $signed(up);
      b = $signed(bo);
      q = 16'(a / b);
      r = 8'(a % b);
    end else begin
      a = int'(up);
      b = int'(bo);
      q = 16'(a / b);
      r = 8'(a % b);
    end
  endfunction

  initial begin
    int          lat;
    logic [15:0] sq, mq, up;
    logic [7:0]  sr, mr, bo;
    logic        sg, seen;

    rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_up = '0; i_bo = '0; i_signed = 1'b0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_quot", o_quot, 0);
    chk("rst_rem", o_rem, 0);
    chk("rst_div0", o_div0, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_busy_u", u_busy, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_ready_u", u_ready, 1);

    directed("u1000_7", 16'd1000, 8'd7, 1'b0, 16'd142, 8'd6, 1'b0, 17);

    // Signed -100/7; the unsigned build sees 65436/7.
    run_op(16'hFF9C, 8'h07, 1'b1, lat);
    chk("sneg_lat", lat, 17);
    chk("sneg_quot", o_quot, 16'hFFF2);
    chk("sneg_rem", o_rem, 8'hFE);
    chk("sneg_u_valid", u_valid, 1);
    chk("sneg_u_quot", u_quot, 16'd9348);
    chk("sneg_u_rem", u_rem, 8'd0);
    finish_op("sneg");

    directed("s100_m7", 16'd100, 8'hF9, 1'b1, 16'hFFF2, 8'd2, 1'b0, 17);
    directed("sm100_m7", 16'hFF9C, 8'hF9, 1'b1, 16'd14, 8'hFE, 1'b0, 17);
    directed("div0", 16'h1234, 8'h00, 1'b0, 16'hFFFF, 8'h34, 1'b1, 1);
    directed("div0_s", 16'hFF9C, 8'h00, 1'b1, 16'hFFFF, 8'h9C, 1'b1, 1);

    // Most-negative / -1 wraps. The unsigned build sees 32768/255.
    run_op(16'h8000, 8'hFF, 1'b1, lat);
    chk("ovf_lat", lat, 17);
    chk("ovf_quot", o_quot, 16'h8000);
    chk("ovf_rem", o_rem, 8'h00);
    chk("ovf_div0", o_div0, 0);
    chk("ovf_u_quot", u_quot, 16'd128);
    chk("ovf_u_rem", u_rem, 8'h80);
    finish_op("ovf");

    directed("u5_9", 16'd5, 8'd9, 1'b0, 16'd0, 8'd5, 1'b0, 17);
    directed("u0_3", 16'd0, 8'd3, 1'b0, 16'd0, 8'd0, 1'b0, 17);

    // Backpressure: hold the result for 10 cycles while stray operands are offered.
    i_ready = 1'b0;
    run_op(16'd12345, 8'd100, 1'b0, lat);
    chk("bp_lat", lat, 17);
    chk("bp_quot", o_quot, 16'd123);
    chk("bp_rem", o_rem, 8'd45);
    sq = o_quot; sr = o_rem;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_up = 16'($urandom); i_bo = 8'd1;
      @(posedge clk); #1;
      chk("bp_hold_valid", o_valid, 1);
      chk("bp_hold_quot", o_quot, sq);
      chk("bp_hold_rem", o_rem, sr);
      chk("bp_hold_ready", o_ready, 0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", o_valid, 0);
    chk("bp_hs_ready", o_ready, 1);
    run_op(16'hFFFF, 8'hFF, 1'b0, lat);
    chk("bp_next_lat", lat, 17);
    chk("bp_next_quot", o_quot, 16'd257);
    chk("bp_next_rem", o_rem, 8'd0);
    finish_op("bp_next");

    // Reset during the fifth CALC cycle.
    i_up = 16'd1000; i_bo = 8'd7; i_signed = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_quot", o_quot, 0);
    chk("mrst_rem", o_rem, 0);
    chk("mrst_div0", o_div0, 0);
    chk("mrst_busy", o_busy, 0);
    @(posedge clk); #3;
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    chk("mrst_no_stale", seen, 0);
    chk("mrst_ready", o_ready, 1);
    directed("mrst_next", 16'd50, 8'd7, 1'b0, 16'd7, 8'd1, 1'b0, 17);

    // Randomized operands against the behavioural model.
    for (int n = 0; n < 200; n++) begin
      up = 16'($urandom);
      bo = 8'($urandom);
      sg = 1'($urandom);
      case ($urandom_range(0, 9))
        0: bo = 8'h00;
        1: up = 16'h8000;
        2: bo = 8'hFF;
        3: up = 16'h0000;
        4: bo = 8'h80;
        default: ;
      endcase
      model(up, bo, sg, mq, mr);
      run_op(up, bo, sg, lat);
      chk("soak_lat", lat, (bo == 8'd0) ? 1 : 17);
      chk("soak_quot", o_quot, mq);
      chk("soak_rem", o_rem, mr);
      chk("soak_div0", o_div0, (bo == 8'd0) ? 1 : 0);
      finish_op("soak");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
